// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Round-robin arbiter that multiplexes NUM_REQ packet streams onto
//            one FIFO write port, holding each grant for a packet or burst cap.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          write_clk,
    input  logic                          write_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          p_write_full,
    output logic                          p_write_en,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [c_PTR_W-1:0]   r_owner, w_owner_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [c_CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [c_PTR_W-1:0]   w_win_idx;
    logic [c_PTR_W-1:0]   w_scan;
    logic                 w_win_found;
    int                   w_scan_idx;
    logic                 w_active;
    logic                 w_accept;
    logic                 w_burst_end;

    // Scan upward from the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan_idx  = 0;
        w_scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan_idx = int'(r_rr_ptr) + i;
            if (w_scan_idx >= NUM_REQ) begin
                w_scan_idx = w_scan_idx - NUM_REQ;
            end
            w_scan = c_PTR_W'(w_scan_idx);
            if (!w_win_found && req_valid[w_scan]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan;
            end
        end
    end

    // Outputs are forced quiet while reset is held, even mid-burst.
    assign w_active    = write_rst_n && (r_state == ST_BURST);
    assign w_accept    = w_active && req_valid[r_owner] && !p_write_full;
    assign w_burst_end = w_accept &&
                         (req_last[r_owner] || (r_beat_cnt == c_CNT_W'(MAX_BURST - 1)));

    always_comb begin
        req_ready = '0;
        if (w_active) begin
            req_ready[r_owner] = !p_write_full;
        end
    end

    assign p_write_en = w_accept;
    assign write_data = w_active ? req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH]
                                 : '0;
    assign grant      = r_grant;
    assign busy       = w_active;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt    = ST_BURST;
                    w_grant_nxt    = NUM_REQ'(1) << w_win_idx;
                    w_owner_nxt    = w_win_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_BURST: begin
                if (w_burst_end) begin
                    w_state_nxt    = ST_IDLE;
                    w_grant_nxt    = '0;
                    w_beat_cnt_nxt = '0;
                    w_rr_ptr_nxt   = (r_owner == c_PTR_W'(NUM_REQ - 1)) ? '0
                                                                          : r_owner + 1'b1;
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (!write_rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Directed self-checking bench for fifo_write_arbiter (4 requesters,
//            8-bit data, burst cap of 4 beats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    logic        write_clk;
    logic        write_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        p_write_full;
    logic        p_write_en;
    logic [7:0]  write_data;
    logic [3:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .write_clk    (write_clk),
        .write_rst_n  (write_rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .p_write_full (p_write_full),
        .p_write_en   (p_write_en),
        .write_data   (write_data),
        .grant        (grant),
        .busy         (busy)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    // {grant, req_ready, p_write_en, busy, write_data}
    function automatic logic [17:0] pk(input logic [3:0] g, input logic [3:0] r,
                                       input logic en, input logic b,
                                       input logic [7:0] d);
        return {g, r, en, b, d};
    endfunction

    logic [17:0] obs;
    logic [17:0] exp_v;
    assign obs = pk(grant, req_ready, p_write_en, busy, write_data);

    always @(negedge write_clk) begin
        total++;
        if (!$onehot0(grant)) begin
            bad++;
            $display("FAIL mon_onehot: grant=%b required one-hot or zero", grant);
        end
        total++;
        if (p_write_en && p_write_full) begin
            bad++;
            $display("FAIL mon_full: p_write_en=1 with p_write_full=1, required en=0");
        end
        total++;
        if (p_write_en && ((grant & req_valid) == 4'b0000)) begin
            bad++;
            $display("FAIL mon_valid: p_write_en=1 grant=%b req_valid=%b, required owner valid",
                     grant, req_valid);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge write_clk);
        #1;
    endtask

    task automatic do_reset;
        write_rst_n  = 1'b0;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        p_write_full = 1'b0;
        tick;
        tick;
        write_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        write_rst_n  = 1'b0;
        req_valid    = 4'hF;
        req_last     = 4'hF;
        req_data     = 32'h33221100;
        p_write_full = 1'b0;
        tick;
        #2;
        total++;
        if (obs !== 18'h0) begin
            bad++;
            $display("FAIL reset_hold: got %h required %h", obs, 18'h0);
        end
        tick;
        write_rst_n = 1'b1;
        req_valid   = '0;
        #2;
        total++;
        if (obs !== 18'h0) begin
            bad++;
            $display("FAIL reset_release: got %h required %h", obs, 18'h0);
        end
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] oh;
        do_reset;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 32'hA3A2A1A0;
        #2;
        total++;
        if (obs !== 18'h0) begin
            bad++;
            $display("FAIL rr_idle0: got %h required %h", obs, 18'h0);
        end
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << order[k];
            tick;
            #2;
            exp_v = pk(oh, oh, 1'b1, 1'b1, 8'hA0 + 8'(order[k]));
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL rr_grant%0d: got %h required %h", k, obs, exp_v);
            end
            tick;
            if (k == 4) req_valid = '0;
            #2;
            total++;
            if (obs !== 18'h0) begin
                bad++;
                $display("FAIL rr_bubble%0d: got %h required %h", k, obs, 18'h0);
            end
        end
    endtask

    task automatic test_full_stall;
        do_reset;
        req_valid      = 4'b0010;
        req_data[15:8] = 8'hB1;
        #2;
        tick;
        #2;
        exp_v = pk(4'b0010, 4'b0010, 1'b1, 1'b1, 8'hB1);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL stall_beat1: got %h required %h", obs, exp_v);
        end
        tick;
        req_data[15:8] = 8'hB2;
        p_write_full   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            exp_v = pk(4'b0010, 4'b0000, 1'b0, 1'b1, 8'hB2);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL stall_full%0d: got %h required %h", c, obs, exp_v);
            end
            tick;
        end
        p_write_full = 1'b0;
        #2;
        exp_v = pk(4'b0010, 4'b0010, 1'b1, 1'b1, 8'hB2);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL stall_beat2: got %h required %h", obs, exp_v);
        end
        tick;
        req_data[15:8] = 8'hB3;
        req_last       = 4'b0010;
        #2;
        exp_v = pk(4'b0010, 4'b0010, 1'b1, 1'b1, 8'hB3);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL stall_beat3: got %h required %h", obs, exp_v);
        end
        tick;
        req_valid = '0;
        #2;
        total++;
        if (obs !== 18'h0) begin
            bad++;
            $display("FAIL stall_end: got %h required %h", obs, 18'h0);
        end
    endtask

    task automatic test_burst_cap;
        do_reset;
        req_valid = 4'b0100;
        #2;
        for (int b = 0; b < 4; b++) begin
            tick;
            req_data[23:16] = 8'hC0 + 8'(b);
            #2;
            exp_v = pk(4'b0100, 4'b0100, 1'b1, 1'b1, 8'hC0 + 8'(b));
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL cap_beat%0d: got %h required %h", b, obs, exp_v);
            end
        end
        tick;
        req_data[23:16] = 8'hC4;
        req_data[31:24] = 8'hF3;
        req_valid       = 4'b1100;
        req_last        = 4'b1000;
        #2;
        total++;
        if (obs !== 18'h0) begin
            bad++;
            $display("FAIL cap_release: got %h required %h", obs, 18'h0);
        end
        tick;
        #2;
        exp_v = pk(4'b1000, 4'b1000, 1'b1, 1'b1, 8'hF3);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL cap_next_is_3: got %h required %h", obs, exp_v);
        end
        tick;
        req_valid = 4'b0100;
        #2;
        tick;
        #2;
        exp_v = pk(4'b0100, 4'b0100, 1'b1, 1'b1, 8'hC4);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL cap_regain_2: got %h required %h", obs, exp_v);
        end
    endtask

    task automatic test_valid_gap;
        do_reset;
        req_valid     = 4'b0001;
        req_data[7:0] = 8'hD0;
        #2;
        tick;
        #2;
        exp_v = pk(4'b0001, 4'b0001, 1'b1, 1'b1, 8'hD0);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL gap_beat1: got %h required %h", obs, exp_v);
        end
        tick;
        req_valid     = '0;
        req_data[7:0] = 8'hD1;
        for (int c = 0; c < 3; c++) begin
            #2;
            exp_v = pk(4'b0001, 4'b0001, 1'b0, 1'b1, 8'hD1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL gap_hold%0d: got %h required %h", c, obs, exp_v);
            end
            tick;
        end
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        #2;
        exp_v = pk(4'b0001, 4'b0001, 1'b1, 1'b1, 8'hD1);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL gap_resume: got %h required %h", obs, exp_v);
        end
        tick;
        req_valid = '0;
        #2;
        total++;
        if (obs !== 18'h0) begin
            bad++;
            $display("FAIL gap_end: got %h required %h", obs, 18'h0);
        end
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        req_valid       = 4'b0100;
        req_last        = 4'b0100;
        req_data[23:16] = 8'h5A;
        #2;
        tick;
        tick;
        req_valid       = 4'b1000;
        req_last        = 4'b0000;
        req_data[31:24] = 8'hE0;
        #2;
        tick;
        #2;
        exp_v = pk(4'b1000, 4'b1000, 1'b1, 1'b1, 8'hE0);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL rstmid_beat1: got %h required %h", obs, exp_v);
        end
        tick;
        req_data[31:24] = 8'hE1;
        write_rst_n     = 1'b0;
        #2;
        total++;
        if (obs[13:0] !== 14'h0) begin
            bad++;
            $display("FAIL rstmid_quiet: got %h required %h", obs[13:0], 14'h0);
        end
        tick;
        write_rst_n    = 1'b1;
        req_valid      = 4'b1010;
        req_last       = 4'b1010;
        req_data[15:8] = 8'h11;
        #2;
        total++;
        if (obs !== 18'h0) begin
            bad++;
            $display("FAIL rstmid_after: got %h required %h", obs, 18'h0);
        end
        tick;
        #2;
        exp_v = pk(4'b0010, 4'b0010, 1'b1, 1'b1, 8'h11);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL rstmid_rearb: got %h required %h", obs, exp_v);
        end
        tick;
        req_valid = '0;
        #2;
    endtask

    initial begin
        write_rst_n  = 1'b0;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        p_write_full = 1'b0;
        test_reset;
        test_round_robin;
        test_full_stall;
        test_burst_cap;
        test_valid_gap;
        test_reset_mid_burst;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the FIFO write port (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, FIFO write data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per grant (1..255).
REQ-004 SHALL use one clock, write_clk; reset write_rst_n is synchronous and active-low.
REQ-005 Ports:
  write_clk  in  1  clock
  write_rst_n  in  1  synchronous active-low reset
  req_valid  in  NUM_REQ  per-requester beat valid
  req_last  in  NUM_REQ  per-requester last beat of packet
  req_data  in  NUM_REQ*DATA_WIDTH  per-requester data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
  req_ready  out  NUM_REQ  per-requester beat accepted when valid&ready
  p_write_full  in  1  FIFO full flag, write domain
  p_write_en  out  1  FIFO write enable
  write_data  out  DATA_WIDTH  FIFO write data
  grant  out  NUM_REQ  one-hot current owner, zero when idle
  busy  out  1  high while a grant is held

Function
REQ-006 SHALL implement a two-state FSM: IDLE, BURST.
REQ-007 IDLE: if any req_valid is high, SHALL register the winner into grant and move to BURST on the next edge; otherwise remain in IDLE.
REQ-008 Winner SHALL be the first requester with req_valid high, searching upward from rr_ptr modulo NUM_REQ (round-robin).
REQ-009 In IDLE, grant, req_ready and p_write_en SHALL all be 0 (one bubble cycle between bursts).
REQ-010 In BURST with owner g: req_ready[g] = !p_write_full; all other req_ready bits SHALL be 0.
REQ-011 In BURST: p_write_en = req_valid[g] & !p_write_full, combinationally, in the same cycle (zero-latency pass-through).
REQ-012 write_data SHALL equal req_data of g in BURST, and 0 in IDLE.
REQ-013 p_write_en SHALL never be high while p_write_full is high.
REQ-014 An accepted beat is p_write_en high; beat_cnt (width clog2(MAX_BURST+1)) SHALL increment on each accepted beat.
REQ-015 The burst SHALL end on the edge of an accepted beat with req_last[g]=1, or on the edge where beat_cnt reaches MAX_BURST.
REQ-016 At burst end: FSM -> IDLE, grant -> 0, beat_cnt -> 0, rr_ptr -> (g+1) mod NUM_REQ.
REQ-017 Owner deasserting req_valid mid-burst SHALL NOT release the grant; the arbiter waits.
REQ-018 p_write_full high mid-burst SHALL stall without losing data or the grant; beat_cnt holds.
REQ-019 Requests from non-owners SHALL be ignored until the next IDLE arbitration.
REQ-020 grant SHALL always be one-hot or zero; busy = (state == BURST).

Reset
REQ-021 On the first edge with write_rst_n low: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
REQ-022 While write_rst_n is low, p_write_en, req_ready, write_data and busy SHALL be 0.
REQ-023 Reset asserted mid-burst SHALL abandon the burst on that edge; the requester retains any unaccepted beats.

Verification
REQ-024 Round-robin: all 4 req_valid high, each sending 1-beat packets (req_last=1) -> grants in order 0,1,2,3,0; exactly one p_write_en per grant; one idle cycle between grants.
REQ-025 Full stall: owner 1 sends a 3-beat packet and p_write_full is high for 5 cycles after beat 1 -> p_write_en low for those 5 cycles; write_data sequence intact; grant stays 4'b0010.
REQ-026 Burst cap: MAX_BURST=4, requester 2 streams 10 beats with no req_last -> release after 4 accepted beats; rr_ptr=3; requester 2 regains grant only if 3 and 0 are idle.
REQ-027 Valid gap: owner 0 drops req_valid for 3 cycles mid-packet -> grant held, no writes during the gap, burst resumes.
REQ-028 Reset mid-burst: write_rst_n low for 1 cycle during requester 3 beat 2 -> next cycle grant=0, p_write_en=0, rr_ptr=0; the next arbitration picks the lowest valid index.
REQ-029 Bench SHALL assert continuously: grant is one-hot or zero; !(p_write_en & p_write_full); p_write_en implies req_valid[g].
